// File: rtl/chirp_mixer_if.sv
// Stream bundle for chirp_mixer: complex audio in, complex chirp/LO in, real mixed audio out.
// The slave modport is the mixer's view; master is the view of whatever drives and drains it.
interface chirp_mixer_if #(
    parameter int G_DIN_WIDTH  = 24,
    parameter int G_LO_WIDTH   = 24,
    parameter int G_DOUT_WIDTH = 24
);
    logic signed [G_DIN_WIDTH-1:0]  audio_re;
    logic signed [G_DIN_WIDTH-1:0]  audio_im;
    logic                           audio_valid;
    logic                           audio_ready;
    logic signed [G_LO_WIDTH-1:0]   lo_re;
    logic signed [G_LO_WIDTH-1:0]   lo_im;
    logic                           lo_valid;
    logic                           lo_ready;
    logic signed [G_DOUT_WIDTH-1:0] dout;
    logic                           dout_valid;
    logic                           dout_ready;
    logic                           sat_flag;

    modport slave (
        input  audio_re, audio_im, audio_valid,
        output audio_ready,
        input  lo_re, lo_im, lo_valid,
        output lo_ready,
        output dout, dout_valid,
        input  dout_ready,
        output sat_flag
    );

    modport master (
        output audio_re, audio_im, audio_valid,
        input  audio_ready,
        output lo_re, lo_im, lo_valid,
        input  lo_ready,
        input  dout, dout_valid,
        output dout_ready,
        input  sat_flag
    );
endinterface

// File: rtl/chirp_mixer.sv
// Vibrato mixer: real part of (audio * chirp), rounded half-up and saturated to output width.
// Three-stage pipeline that moves as a whole on 'advance'; both input streams join on one edge.
module chirp_mixer #(
    parameter int G_DIN_WIDTH  = 24,
    parameter int G_LO_WIDTH   = 24,
    parameter int G_DOUT_WIDTH = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    chirp_mixer_if.slave bus
);
    localparam int PW = G_DIN_WIDTH + G_LO_WIDTH;
    localparam int SW = PW + 1;

    localparam logic signed [SW-1:0] RND_BIAS = SW'(1) << (G_LO_WIDTH - 2);
    localparam logic signed [SW-1:0] OUT_MAX  = {{(SW-G_DOUT_WIDTH+1){1'b0}}, {(G_DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] OUT_MIN  = {{(SW-G_DOUT_WIDTH+1){1'b1}}, {(G_DOUT_WIDTH-1){1'b0}}};

    logic advance;
    logic fire;

    logic signed [G_DIN_WIDTH-1:0]  s1_are, s1_aim;
    logic signed [G_LO_WIDTH-1:0]   s1_lre, s1_lim;
    logic                           s1_valid;
    logic signed [PW-1:0]           s2_prr, s2_pii;
    logic                           s2_valid;
    logic signed [G_DOUT_WIDTH-1:0] dout_r;
    logic                           dout_valid_r;
    logic                           sat_r;

    logic signed [SW-1:0]           sum, rnd, q;
    logic signed [G_DOUT_WIDTH-1:0] result;
    logic                           clip;

    // Holding reset or dropping enable freezes intake so nothing is consumed while clearing.
    assign advance         = enable & ~reset & (~dout_valid_r | bus.dout_ready);
    assign fire            = bus.audio_valid & bus.lo_valid & advance;
    assign bus.audio_ready = bus.lo_valid & advance;
    assign bus.lo_ready    = bus.audio_valid & advance;
    assign bus.dout        = dout_r;
    assign bus.dout_valid  = dout_valid_r;
    assign bus.sat_flag    = sat_r;

    always_comb begin
        sum    = $signed({s2_prr[PW-1], s2_prr}) - $signed({s2_pii[PW-1], s2_pii});
        rnd    = sum + RND_BIAS;
        q      = rnd >>> (G_LO_WIDTH - 1);
        clip   = 1'b0;
        result = q[G_DOUT_WIDTH-1:0];
        if (q > OUT_MAX) begin
            clip   = 1'b1;
            result = OUT_MAX[G_DOUT_WIDTH-1:0];
        end else if (q < OUT_MIN) begin
            clip   = 1'b1;
            result = OUT_MIN[G_DOUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            dout_valid_r <= 1'b0;
            dout_r       <= '0;
            sat_r        <= 1'b0;
        end else if (advance) begin
            s1_are       <= bus.audio_re;
            s1_aim       <= bus.audio_im;
            s1_lre       <= bus.lo_re;
            s1_lim       <= bus.lo_im;
            s1_valid     <= fire;
            s2_prr       <= s1_are * s1_lre;
            s2_pii       <= s1_aim * s1_lim;
            s2_valid     <= s1_valid;
            dout_r       <= result;
            dout_valid_r <= s2_valid;
            if (s2_valid && clip)
                sat_r <= 1'b1;
        end
    end
endmodule

// File: doc/chirp_mixer.md
# chirp_mixer

Downstream consumer of the cyclic chirp generator in the vibrato path. Joins a complex audio stream (analytic signal from the Hilbert stage) with the complex chirp/LO stream, forms the real part of their complex product, rounds and saturates it back to audio width, and emits a real sample stream. Result is the frequency-modulated (vibrato) audio. Three-stage pipeline with global stall; all interfaces are valid/ready.

## Interface
Parameters:
- G_DIN_WIDTH, 24, signed audio component width (re and im)
- G_LO_WIDTH, 24, signed chirp component width, format Q1.(G_LO_WIDTH-1)
- G_DOUT_WIDTH, 24, signed output width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  0 acts as synchronous reset (same effect as reset)
- audio_re  in  G_DIN_WIDTH  audio real part, signed
- audio_im  in  G_DIN_WIDTH  audio imaginary part, signed
- audio_valid  in  1  audio beat present
- audio_ready  out  1  audio beat accepted when audio_valid & audio_ready
- lo_re  in  G_LO_WIDTH  chirp real part, signed (cyclic_chirp dout_re)
- lo_im  in  G_LO_WIDTH  chirp imaginary part, signed (cyclic_chirp dout_im)
- lo_valid  in  1  chirp beat present
- lo_ready  out  1  chirp beat accepted when lo_valid & lo_ready
- dout  out  G_DOUT_WIDTH  mixed real output, signed
- dout_valid  out  1  output beat present
- dout_ready  in  1  downstream accepts
- sat_flag  out  1  sticky: set when any output saturated; cleared only by reset/enable=0

## Operation
- advance = ~dout_valid | dout_ready (combinational). All three stages move together on advance; none move otherwise.
- Join: fire = audio_valid & lo_valid & advance. audio_ready = lo_valid & advance; lo_ready = audio_valid & advance. Both streams consumed on the same edge, never one alone.
- Stage 1 (on advance): register audio_re/im, lo_re/im; s1_valid <= fire.
- Stage 2 (on advance): p_rr = audio_re*lo_re, p_ii = audio_im*lo_im, each signed G_DIN_WIDTH+G_LO_WIDTH bits; s2_valid <= s1_valid.
- Stage 3 (on advance): sum = p_rr - p_ii at G_DIN_WIDTH+G_LO_WIDTH+1 bits; rnd = sum + 2^(G_LO_WIDTH-2); q = rnd >>> (G_LO_WIDTH-1) (arithmetic; round half toward +inf); saturate q to [-2^(G_DOUT_WIDTH-1), 2^(G_DOUT_WIDTH-1)-1]; dout <= result; dout_valid <= s2_valid; if s2_valid and clipped, sat_flag <= 1.
- No bubble compression: an empty stage still occupies its slot.
- dout and dout_valid are registers; held stable while dout_valid & ~dout_ready.
- reset or enable=0: s1/s2 valids, dout_valid, dout, sat_flag all cleared the same edge; in-flight beats discarded; readies low while asserted (advance forced 0).

## Timing
- Reset values: dout=0, dout_valid=0, sat_flag=0, audio_ready=0, lo_ready=0.
- Latency: join fires in cycle n -> dout_valid=1 with that result in cycle n+3 (dout_ready held high).
- Throughput: one beat per cycle with both inputs valid and dout_ready=1.
- Backpressure: dout_valid=1 & dout_ready=0 -> both readies 0 the same cycle; pipeline frozen; up to 3 beats held in flight; none lost or duplicated.
- Simultaneous: dout accepted and new join fire in the same cycle is legal; both occur.
- Only one input valid: no fire, neither ready-side consumption; the valid side waits, stage 1 takes a bubble.
- Readies are combinational from the other stream's valid and dout_ready; no combinational path from audio data to dout.

## Test plan
- Basic: audio_re=0x100000, audio_im=0, lo_re=0x400000, lo_im=0x123456 -> dout=0x080000 exactly 3 cycles after fire, sat_flag=0.
- Rounding: audio_re=1, lo_re=0x400000 (others 0) -> dout=1; audio_re=-1 (0xFFFFFF), lo_re=0x400000 -> dout=0.
- Saturation: audio_re=0x7FFFFF, audio_im=0x800000, lo_re=0x7FFFFF, lo_im=0x7FFFFF -> dout=0x7FFFFF, sat_flag=1 and stays 1; audio_re=0x800000, lo_re=0x800000 -> dout=0x7FFFFF; audio_re=0x800000, lo_re=0x7FFFFF -> dout=0x800001, no new saturation.
- Join/backpressure: 100 random beats, audio_valid/lo_valid/dout_ready each randomly toggled -> output sequence equals reference model in order, no drops/duplicates, dout stable while stalled, readies never high while frozen.
- Reset mid-stream: 3 beats in flight, reset pulse one cycle -> next cycle dout_valid=0, dout=0, sat_flag=0, readies 0; first post-reset fire yields output at +3 cycles with no stale data.
- enable=0 for 5 cycles mid-stream -> identical behaviour to reset; readies stay 0 until enable returns.
